uart_msg_receiver: RTL and testbench

- Serial command receiver for the vehicle controller.
- When armed by the controller's loadStart, it captures a 3-byte message from the RX line: left motor, right motor, duration.
- Frame format is 8N1 with the MSB sent first.
- It latches the three bytes onto parallel outputs and raises loadComplete for the controller/executeCommand stage.

---
 rtl/vehicle_pkg.sv | 23 ++
 rtl/uart_byte_rx.sv | 110 +++++++++++
 rtl/uart_msg_receiver.sv | 104 ++++++++++
 tb/tb_uart_msg_receiver.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/vehicle_pkg.sv
// Shared definitions for the vehicle controller's serial command path:
// receiver state encoding, bit timing default and message byte layout.
package vehicle_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        START_CHK,
        DATA,
        STOP,
        DONE
    } state_t;

    // 10 MHz clock, 17.6 us per serial bit
    localparam int CLKS_PER_BIT_DEFAULT = 176;

    localparam int MSG_BYTES = 3;

    localparam logic [1:0] IDX_LMOTOR = 2'd0;
    localparam logic [1:0] IDX_RMOTOR = 2'd1;
    localparam logic [1:0] IDX_DUR    = 2'd2;

endpackage

// File: rtl/uart_byte_rx.sv
// Single 8N1 byte receiver, MSB first: RX synchronizer, start-bit centre check,
// centre sampling of 8 data bits and stop-bit check with framing-error pulse.
module uart_byte_rx
    import vehicle_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       enable,
    output logic [7:0] rx_data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0] FULL_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

    logic          rx_meta_reg;
    logic          rx_sync_reg;
    logic          line_idle_reg;
    state_t        state_reg;
    logic [BW-1:0] baud_cnt_reg;
    logic [2:0]    bit_cnt_reg;
    logic [7:0]    shreg_reg;
    logic          stop_tick;

    assign stop_tick  = (state_reg == STOP) && (baud_cnt_reg == FULL_LAST);
    // Pulses coincide with the stop-bit sample so the parent can latch on the same edge.
    assign byte_valid = enable && stop_tick && rx_sync_reg;
    assign frame_err  = enable && stop_tick && !rx_sync_reg;
    assign rx_data    = shreg_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta_reg   <= 1'b1;
            rx_sync_reg   <= 1'b1;
            line_idle_reg <= 1'b1;
            state_reg     <= IDLE;
            baud_cnt_reg  <= '0;
            bit_cnt_reg   <= '0;
            shreg_reg     <= '0;
        end else begin
            rx_meta_reg <= rx;
            rx_sync_reg <= rx_meta_reg;
            if (rx_sync_reg) begin
                line_idle_reg <= 1'b1;
            end

            if (!enable) begin
                state_reg    <= IDLE;
                baud_cnt_reg <= '0;
                bit_cnt_reg  <= '0;
            end else begin
                case (state_reg)
                    IDLE: begin
                        baud_cnt_reg <= '0;
                        bit_cnt_reg  <= '0;
                        state_reg    <= WAIT_START;
                    end
                    WAIT_START: begin
                        // After a framing error the line must go high before a new start counts.
                        if (!rx_sync_reg && line_idle_reg) begin
                            baud_cnt_reg <= '0;
                            state_reg    <= START_CHK;
                        end
                    end
                    START_CHK: begin
                        if (baud_cnt_reg == HALF_LAST) begin
                            baud_cnt_reg <= '0;
                            bit_cnt_reg  <= '0;
                            state_reg    <= rx_sync_reg ? WAIT_START : DATA;
                        end else begin
                            baud_cnt_reg <= baud_cnt_reg + 1'b1;
                        end
                    end
                    DATA: begin
                        if (baud_cnt_reg == FULL_LAST) begin
                            baud_cnt_reg <= '0;
                            shreg_reg    <= {shreg_reg[6:0], rx_sync_reg};
                            bit_cnt_reg  <= bit_cnt_reg + 3'd1;
                            if (bit_cnt_reg == 3'd7) begin
                                state_reg <= STOP;
                            end
                        end else begin
                            baud_cnt_reg <= baud_cnt_reg + 1'b1;
                        end
                    end
                    STOP: begin
                        if (baud_cnt_reg == FULL_LAST) begin
                            baud_cnt_reg <= '0;
                            state_reg    <= WAIT_START;
                            if (!rx_sync_reg) begin
                                line_idle_reg <= 1'b0;
                            end
                        end else begin
                            baud_cnt_reg <= baud_cnt_reg + 1'b1;
                        end
                    end
                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/uart_msg_receiver.sv
// Collects a 3-byte motor command (lmotor, rmotor, dur) from the serial line
// while loadStart is high and presents it with loadComplete until loadStart drops.
module uart_msg_receiver
    import vehicle_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RX,
    input  logic       loadStart,
    output logic [7:0] lmotor,
    output logic [7:0] rmotor,
    output logic [7:0] dur,
    output logic       loadComplete
);

    state_t     state_reg;
    logic [1:0] byte_idx_reg;
    logic [7:0] stage_reg [MSG_BYTES-1];
    logic       rx_en;
    logic [7:0] rx_data;
    logic       byte_valid;
    logic       frame_err;
    logic       accept;

    assign rx_en  = (state_reg == WAIT_START) && loadStart;
    assign accept = rx_en && byte_valid;

    uart_byte_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_byte_rx (
        .clk       (clk),
        .reset     (reset),
        .rx        (RX),
        .enable    (rx_en),
        .rx_data   (rx_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    // Leading bytes are staged; the last byte goes straight to the outputs
    // so all three update together on the edge loadComplete rises.
    generate
        for (genvar gi = 0; gi < MSG_BYTES - 1; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (reset) begin
                    stage_reg[gi] <= '0;
                end else if (accept && (byte_idx_reg == 2'(gi))) begin
                    stage_reg[gi] <= rx_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            byte_idx_reg <= '0;
            lmotor       <= '0;
            rmotor       <= '0;
            dur          <= '0;
            loadComplete <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    loadComplete <= 1'b0;
                    byte_idx_reg <= '0;
                    if (loadStart) begin
                        state_reg <= WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (!loadStart) begin
                        byte_idx_reg <= '0;
                        state_reg    <= IDLE;
                    end else if (byte_valid) begin
                        if (byte_idx_reg == IDX_DUR) begin
                            lmotor       <= stage_reg[int'(IDX_LMOTOR)];
                            rmotor       <= stage_reg[int'(IDX_RMOTOR)];
                            dur          <= rx_data;
                            loadComplete <= 1'b1;
                            state_reg    <= DONE;
                        end else begin
                            byte_idx_reg <= byte_idx_reg + 2'd1;
                        end
                    end else if (frame_err) begin
                        byte_idx_reg <= '0;
                    end
                end
                DONE: begin
                    if (!loadStart) begin
                        loadComplete <= 1'b0;
                        state_reg    <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_msg_receiver.sv
// Bench for uart_msg_receiver: serial stimulus at 176 clk/bit with a scoreboard
// of expected messages and loadComplete rise cycles.
`timescale 1ns/1ps
module tb_uart_msg_receiver;

    localparam int CPB = 176;
    localparam int GAP = 1000;
    // Clocks from driving the last stop bit to seeing loadComplete high:
    // 2 synchronizer flops + half-bit centre offset + 1 output register.
    localparam int LAT = 91;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       RX = 1'b1;
    logic       loadStart = 1'b0;
    logic [7:0] lmotor;
    logic [7:0] rmotor;
    logic [7:0] dur;
    logic       loadComplete;

    always #50 clk = ~clk;

    uart_msg_receiver uut (
        .clk         (clk),
        .reset       (reset),
        .RX          (RX),
        .loadStart   (loadStart),
        .lmotor      (lmotor),
        .rmotor      (rmotor),
        .dur         (dur),
        .loadComplete(loadComplete)
    );

    typedef struct {
        logic [7:0] lm;
        logic [7:0] rm;
        logic [7:0] du;
        int         rise_cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic lc_prev = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (loadComplete && !lc_prev) begin
            check("sb_pending", 32'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                check("msg_lmotor", lmotor, mon_e.lm);
                check("msg_rmotor", rmotor, mon_e.rm);
                check("msg_dur", dur, mon_e.du);
                check("msg_rise_cyc", cyc, mon_e.rise_cyc);
                $display("msg lmotor=%02h rmotor=%02h dur=%02h cyc=%0d", lmotor, rmotor, dur, cyc);
            end
        end
        lc_prev <= loadComplete;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 7; i >= 0; i--) begin
            RX = b[i];
            repeat (CPB) @(negedge clk);
        end
        RX = stop_bit;
        repeat (CPB) @(negedge clk);
        RX = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_msg(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        exp_t e;
        send_byte(a, 1'b1);
        send_byte(b, 1'b1);
        e.lm = a;
        e.rm = b;
        e.du = c;
        e.rise_cyc = cyc + 9 * CPB + LAT;
        sb.push_back(e);
        send_byte(c, 1'b1);
    endtask

    task automatic rearm();
        loadStart = 1'b0;
        repeat (3) @(negedge clk);
        loadStart = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #9_000_000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "simulation time limit");
    end

    initial begin
        repeat (5) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_lmotor", lmotor, 8'h00);
        check("rst_rmotor", rmotor, 8'h00);
        check("rst_dur", dur, 8'h00);
        check("rst_lc", loadComplete, 1'b0);
        loadStart = 1'b1;
        repeat (10) @(negedge clk);

        // nominal message
        send_msg(8'h95, 8'hB6, 8'h35);
        check("nom_lc", loadComplete, 1'b1);

        // handshake: extra byte ignored while complete, then 1-clk drop
        send_byte(8'h5A, 1'b1);
        check("hs_hold_lm", lmotor, 8'h95);
        check("hs_hold_rm", rmotor, 8'hB6);
        check("hs_hold_dur", dur, 8'h35);
        check("hs_hold_lc", loadComplete, 1'b1);
        loadStart = 1'b0;
        @(negedge clk);
        loadStart = 1'b1;
        check("hs_drop_lc", loadComplete, 1'b0);
        repeat (10) @(negedge clk);
        send_msg(8'h01, 8'h02, 8'h03);

        // glitch rejection
        rearm();
        RX = 1'b0;
        repeat (40) @(negedge clk);
        RX = 1'b1;
        repeat (GAP) @(negedge clk);
        check("glitch_lc", loadComplete, 1'b0);
        send_msg(8'hC3, 8'h3C, 8'h7E);

        // framing error on first byte
        rearm();
        send_byte(8'hAA, 1'b0);
        check("frame_lc", loadComplete, 1'b0);
        send_msg(8'h11, 8'h22, 8'h33);

        // abort after first byte
        rearm();
        send_byte(8'h44, 1'b1);
        loadStart = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_lc", loadComplete, 1'b0);
        check("abort_lm", lmotor, 8'h11);
        check("abort_rm", rmotor, 8'h22);
        check("abort_dur", dur, 8'h33);
        loadStart = 1'b1;
        repeat (10) @(negedge clk);
        send_msg(8'h66, 8'h77, 8'h88);

        // reset during data bits of the second byte
        rearm();
        send_byte(8'h9A, 1'b1);
        RX = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            RX = i[0];
            repeat (CPB) @(negedge clk);
        end
        reset = 1'b1;
        RX = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("mrst_lm", lmotor, 8'h00);
        check("mrst_rm", rmotor, 8'h00);
        check("mrst_dur", dur, 8'h00);
        check("mrst_lc", loadComplete, 1'b0);
        repeat (GAP) @(negedge clk);
        send_msg(8'hA1, 8'hB2, 8'hC3);

        repeat (20) @(negedge clk);
        check("sb_drain", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
